sal_refresh_ctrl: RTL and testbench

//   Generates periodic all-bank AUTO-REFRESH for the DDR2 controller.
//   - Counts tREFI and accumulates owed refreshes (bounded postponement).
//   - Drains every bank controller through its per-bank refresh req/gnt pair.
//   - Hands one REF command per owed refresh to the scheduler, then honours tRFC.
//   - Sits between the config block (timing values) and the bank controllers/scheduler.
//

---
 rtl/sal_refresh_ctrl.sv | 141 ++++++++++++++
 tb/tb_sal_refresh_ctrl.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sal_refresh_ctrl.sv
// sal_refresh_ctrl: periodic all-bank AUTO-REFRESH generator for the DDR2 controller.
// Counts tREFI, tracks owed refreshes, drains the bank controllers, issues one REF
// per owed refresh to the scheduler and honours tRFC between them.
module sal_refresh_ctrl #(
  parameter int unsigned BK_CNT   = 4,
  parameter int unsigned TREFI_W  = 16,
  parameter int unsigned TRFC_W   = 8,
  parameter int unsigned MAX_PEND = 8,
  localparam int unsigned PEND_W  = $clog2(MAX_PEND + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ref_en_i,
  input  logic [TREFI_W-1:0] cfg_trefi_i,
  input  logic [TRFC_W-1:0]  cfg_trfc_i,
  output logic [BK_CNT-1:0]  bk_ref_req_o,
  input  logic [BK_CNT-1:0]  bk_ref_gnt_i,
  output logic               ref_cmd_req_o,
  input  logic               ref_cmd_gnt_i,
  output logic               ref_busy_o,
  output logic [PEND_W-1:0]  pend_cnt_o,
  output logic               ref_ovf_o
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DRAIN    = 2'd1,
    ST_ISSUE    = 2'd2,
    ST_WAIT_RFC = 2'd3
  } state_t;

  state_t              state;
  state_t              next_state;
  logic [TREFI_W-1:0]  trefi_cnt;
  logic [TRFC_W-1:0]   rfc_cnt;
  logic                tick;
  logic                ref_hs;
  logic [BK_CNT-1:0]   bk_req_d;
  logic                cmd_req_d;
  logic                busy_d;

  assign tick   = ref_en_i && (cfg_trefi_i != '0) && (trefi_cnt == '0);
  assign ref_hs = ref_cmd_req_o && ref_cmd_gnt_i;

  // tREFI down-counter: free-running, frozen while disabled or unconfigured
  always_ff @(posedge clk) begin
    if (rst) begin
      trefi_cnt <= cfg_trefi_i - TREFI_W'(1);
    end else if (ref_en_i && (cfg_trefi_i != '0)) begin
      if (trefi_cnt == '0) begin
        trefi_cnt <= cfg_trefi_i - TREFI_W'(1);
      end else begin
        trefi_cnt <= trefi_cnt - TREFI_W'(1);
      end
    end
  end

  // Owed-refresh accounting with saturation and sticky overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_cnt_o <= '0;
      ref_ovf_o  <= 1'b0;
    end else if (tick && !ref_hs) begin
      if (pend_cnt_o == PEND_W'(MAX_PEND)) begin
        ref_ovf_o <= 1'b1;
      end else begin
        pend_cnt_o <= pend_cnt_o + PEND_W'(1);
      end
    end else if (ref_hs && !tick) begin
      pend_cnt_o <= pend_cnt_o - PEND_W'(1);
    end
  end

  // tRFC counter: loaded on REF handshake, counts down while waiting
  always_ff @(posedge clk) begin
    if (rst) begin
      rfc_cnt <= '0;
    end else if (ref_hs) begin
      rfc_cnt <= cfg_trfc_i - TRFC_W'(1);
    end else if ((state == ST_WAIT_RFC) && (rfc_cnt != '0)) begin
      rfc_cnt <= rfc_cnt - TRFC_W'(1);
    end
  end

  // FSM state and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      bk_ref_req_o  <= '0;
      ref_cmd_req_o <= 1'b0;
      ref_busy_o    <= 1'b0;
    end else begin
      state         <= next_state;
      bk_ref_req_o  <= bk_req_d;
      ref_cmd_req_o <= cmd_req_d;
      ref_busy_o    <= busy_d;
    end
  end

  // Next-state and next-output decode
  always_comb begin
    next_state = state;
    bk_req_d   = '0;
    cmd_req_d  = 1'b0;
    busy_d     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (ref_en_i && (pend_cnt_o != '0)) next_state = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!ref_en_i) begin
          next_state = ST_IDLE;
        end else if (&bk_ref_gnt_i) begin
          next_state = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (ref_hs) next_state = ST_WAIT_RFC;
      end
      ST_WAIT_RFC: begin
        if (rfc_cnt == '0) begin
          if ((pend_cnt_o != '0) && ref_en_i) begin
            next_state = ST_ISSUE;
          end else begin
            next_state = ST_IDLE;
          end
        end
      end
      default: next_state = ST_IDLE;
    endcase
    // Command request appears one cycle after entering ISSUE and drops on handshake
    cmd_req_d = (state == ST_ISSUE) && (next_state == ST_ISSUE);
    busy_d    = (next_state != ST_IDLE);
    bk_req_d  = busy_d ? {BK_CNT{1'b1}} : {BK_CNT{1'b0}};
  end

  // Banks must stay granted while a REF is being issued or tRFC is running
  a_gnt_held: assert property (@(posedge clk) disable iff (rst)
    ((state == ST_ISSUE) || (state == ST_WAIT_RFC)) |-> (&bk_ref_gnt_i));

endmodule

// File: tb/tb_sal_refresh_ctrl.sv
// tb_sal_refresh_ctrl: directed scenarios with a REF-handshake scoreboard.
// Expected REF handshakes (cycle relative to last reset, pend_cnt at handshake)
// are queued by the stimulus; a monitor pops and compares on every handshake.
module tb_sal_refresh_ctrl;

  localparam int unsigned BK_CNT   = 4;
  localparam int unsigned TREFI_W  = 16;
  localparam int unsigned TRFC_W   = 8;
  localparam int unsigned MAX_PEND = 8;
  localparam int unsigned PEND_W   = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic               ref_en;
  logic [TREFI_W-1:0] cfg_trefi;
  logic [TRFC_W-1:0]  cfg_trfc;
  logic [BK_CNT-1:0]  bk_req;
  logic [BK_CNT-1:0]  bk_gnt;
  logic [BK_CNT-1:0]  gnt_mask;
  logic               cmd_req;
  logic               cmd_gnt;
  logic               cmd_gnt_en;
  logic               busy;
  logic [PEND_W-1:0]  pend;
  logic               ovf;

  typedef struct {
    int rel;
    int pend;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   t0       = 0;

  sal_refresh_ctrl #(
    .BK_CNT  (BK_CNT),
    .TREFI_W (TREFI_W),
    .TRFC_W  (TRFC_W),
    .MAX_PEND(MAX_PEND)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .ref_en_i     (ref_en),
    .cfg_trefi_i  (cfg_trefi),
    .cfg_trfc_i   (cfg_trfc),
    .bk_ref_req_o (bk_req),
    .bk_ref_gnt_i (bk_gnt),
    .ref_cmd_req_o(cmd_req),
    .ref_cmd_gnt_i(cmd_gnt),
    .ref_busy_o   (busy),
    .pend_cnt_o   (pend),
    .ref_ovf_o    (ovf)
  );

  // Bank controllers grant as soon as asked unless masked; scheduler likewise
  assign bk_gnt  = bk_req & ~gnt_mask;
  assign cmd_gnt = cmd_req & cmd_gnt_en;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (rel cycle %0d)", name, act, req, cyc - t0);
    end
  endtask

  task automatic push(input int rel, input int p);
    exp_t e;
    e.rel  = rel;
    e.pend = p;
    exp_q.push_back(e);
  endtask

  task automatic wait_rel(input int k);
    while ((cyc - t0) < k) @(negedge clk);
  endtask

  task automatic drained(input string name);
    chk(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  // One reset edge; rel 0 is the negedge right after it
  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    t0 = cyc;
    chk("rst_bk_req", int'(bk_req), 0);
    chk("rst_cmd_req", int'(cmd_req), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_pend", int'(pend), 0);
    chk("rst_ovf", int'(ovf), 0);
    rst = 1'b0;
  endtask

  // Scoreboard monitor: every REF handshake must match the head of the queue
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (!rst && cmd_req && cmd_gnt) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_ref: REF handshake at rel cycle %0d, none expected", cyc - t0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("ref_cycle", cyc - t0, mon_e.rel);
          chk("ref_pend", int'(pend), mon_e.pend);
        end
      end
    end
  end

  initial begin
    int hold;
    int low;
    rst        = 1'b1;
    ref_en     = 1'b1;
    cfg_trefi  = 16'd100;
    cfg_trfc   = 8'd10;
    gnt_mask   = 4'h0;
    cmd_gnt_en = 1'b1;

    // 1: steady state, REF every tREFI
    do_reset();
    push(103, 1);
    push(203, 1);
    push(303, 1);
    hold = 0;
    for (int k = 99; k <= 130; k++) begin
      wait_rel(k);
      if (bk_req == 4'hF) hold++;
      case (k)
        99:  chk("t1_pend_pre", int'(pend), 0);
        100: begin
          chk("t1_pend_tick", int'(pend), 1);
          chk("t1_busy_idle", int'(busy), 0);
        end
        101: begin
          chk("t1_busy", int'(busy), 1);
          chk("t1_bk_req", int'(bk_req), 15);
        end
        102: chk("t1_cmd_not_yet", int'(cmd_req), 0);
        103: chk("t1_cmd_req", int'(cmd_req), 1);
        104: chk("t1_pend_dec", int'(pend), 0);
        default: ;
      endcase
    end
    chk("t1_hold_cycles", hold, 13);
    wait_rel(310);
    drained("t1_drained");

    // 2: bank 2 withholds grant for 500 cycles, then five back-to-back REFs
    gnt_mask = 4'b0100;
    do_reset();
    for (int i = 0; i < 5; i++) push(502 + 12 * i, 5 - i);
    push(603, 1);
    low = 0;
    for (int k = 101; k <= 560; k++) begin
      wait_rel(k);
      if (bk_req != 4'hF) low++;
      if (k == 500) begin
        chk("t2_pend_5", int'(pend), 5);
        gnt_mask = 4'h0;
      end
    end
    chk("t2_req_low_cycles", low, 0);
    wait_rel(561);
    chk("t2_req_released", int'(bk_req), 0);
    wait_rel(610);
    drained("t2_drained");

    // 3: grants blocked 1000 cycles, saturation and sticky overflow
    gnt_mask = 4'hF;
    do_reset();
    for (int i = 0; i < 8; i++) push(1002 + 12 * i, 8 - i);
    wait_rel(800);
    chk("t3_pend_sat", int'(pend), 8);
    chk("t3_ovf_pre", int'(ovf), 0);
    wait_rel(899);
    chk("t3_pend_899", int'(pend), 8);
    chk("t3_ovf_899", int'(ovf), 0);
    wait_rel(900);
    chk("t3_ovf_set", int'(ovf), 1);
    chk("t3_pend_held", int'(pend), 8);
    wait_rel(1000);
    chk("t3_ovf_1000", int'(ovf), 1);
    gnt_mask = 4'h0;
    wait_rel(1095);
    chk("t3_ovf_sticky", int'(ovf), 1);
    chk("t3_pend_zero", int'(pend), 0);
    drained("t3_drained");

    // 4: REF handshake lands on a tick with pend_cnt=1
    cmd_gnt_en = 1'b0;
    do_reset();
    push(199, 1);
    push(211, 1);
    push(303, 1);
    wait_rel(103);
    chk("t4_cmd_waiting", int'(cmd_req), 1);
    wait_rel(198);
    chk("t4_pend_198", int'(pend), 1);
    wait_rel(199);
    cmd_gnt_en = 1'b1;
    wait_rel(200);
    chk("t4_pend_net", int'(pend), 1);
    chk("t4_cmd_dropped", int'(cmd_req), 0);
    chk("t4_busy", int'(busy), 1);
    wait_rel(212);
    chk("t4_pend_after", int'(pend), 0);
    wait_rel(310);
    drained("t4_drained");

    // 5a: enable dropped while draining
    gnt_mask = 4'hF;
    do_reset();
    wait_rel(101);
    chk("t5a_bk_req", int'(bk_req), 15);
    wait_rel(120);
    ref_en = 1'b0;
    wait_rel(121);
    chk("t5a_bk_dropped", int'(bk_req), 0);
    chk("t5a_busy", int'(busy), 0);
    chk("t5a_pend", int'(pend), 1);
    wait_rel(250);
    chk("t5a_timer_held", int'(pend), 1);
    drained("t5a_drained");

    // 5b: enable dropped during tRFC, current REF completes then idle
    do_reset();
    ref_en = 1'b1;
    push(202, 2);
    wait_rel(200);
    chk("t5b_pend_2", int'(pend), 2);
    gnt_mask = 4'h0;
    wait_rel(205);
    ref_en = 1'b0;
    wait_rel(210);
    chk("t5b_busy_rfc", int'(busy), 1);
    chk("t5b_bk_rfc", int'(bk_req), 15);
    wait_rel(213);
    chk("t5b_busy_idle", int'(busy), 0);
    chk("t5b_bk_idle", int'(bk_req), 0);
    chk("t5b_pend_left", int'(pend), 1);
    wait_rel(230);
    drained("t5b_drained");

    // 6: reset during tRFC with pend_cnt=3
    gnt_mask = 4'hF;
    do_reset();
    ref_en = 1'b1;
    push(402, 4);
    wait_rel(400);
    chk("t6_pend_4", int'(pend), 4);
    gnt_mask = 4'h0;
    wait_rel(405);
    chk("t6_pend_3", int'(pend), 3);
    chk("t6_busy", int'(busy), 1);
    do_reset();
    push(103, 1);
    wait_rel(99);
    chk("t6_pend_pre", int'(pend), 0);
    wait_rel(100);
    chk("t6_pend_tick", int'(pend), 1);
    wait_rel(110);
    drained("t6_drained");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
